regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (enc/addrc/datac) between two writeback requesters: ALU and memory-load.
- Keeps a per-register pending-write scoreboard. The issue stage uses it to detect read-after-write hazards on the two read ports.
- Sits between the execute/memory stages and the register file. Its write-port outputs connect directly to the register file's enc, addrc and datac inputs.

Parameters:
DATA_W, 32, width of register data
ADDR_W, 5, register address width
NREG, 32, number of registers (2**ADDR_W)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
rsv_en  in  1  issue stage reserves a destination register
rsv_addr  in  ADDR_W  register being reserved
chk_addra  in  ADDR_W  source A address being issued
chk_addrb  in  ADDR_W  source B address being issued
hazard_a  out  1  source A has a pending or in-flight write
hazard_b  out  1  source B has a pending or in-flight write
enc  out  1  register file write enable
addrc  out  ADDR_W  register file write address
datac  out  DATA_W  register file write data
busy  out  NREG  scoreboard vector; bit i set = register i pending

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - enc=0, addrc=0, datac=0, busy=0, last_grant=MEM.
  - alu_ready=0 and mem_ready=0.
  - Any in-flight write is dropped.
- Arbitration is combinational, with at most one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not recorded in last_grant, i.e. round-robin. The first tie after reset goes to ALU.
  - *_ready = grant. A transfer occurs on a rising edge where valid && ready.
  - A requester holds valid, addr and data stable until ready.
- last_grant is updated only on a transfer.
- Write-port timing is one registered stage:
  - A transfer at edge N drives enc=1 with addrc/datac during cycle N..N+1.
  - The register file writes at edge N+1.
  - With no transfer, enc=0 the next cycle; addrc/datac hold their previous values.
- Register 0:
  - A transfer to address 0 completes its handshake, but enc stays 0 for it.
  - rsv_en with rsv_addr=0 is ignored; busy[0] is always 0.
- Scoreboard, evaluated at each edge:
  - clear: bit addr is cleared on a transfer to addr.
  - set: bit rsv_addr is set when rsv_en is high.
  - Set and clear of the same address in the same edge: set wins, because a newer writer is pending.
  - Reserving an already-busy register leaves it set. Only one outstanding writer per register is tracked.
- Hazard outputs are combinational:
  - hazard_a = (chk_addra != 0) && (busy[chk_addra] || (enc && addrc == chk_addra)). hazard_b is the same for chk_addrb.
  - The in-flight term covers the cycle in which the register file has not yet committed the write. Its reads are registered, so a read at the commit edge would return stale data.
- Transfers are accepted regardless of busy state. A writeback to an unreserved register is legal and writes normally.
- If reset asserts mid-cycle, outputs clear immediately. After deassertion, the first edge behaves as if after power-up.

Test Plan:
- Reset, then alu_valid=1, addr=5, data=0xDEADBEEF for one transfer -> alu_ready=1 that cycle; next cycle enc=1, addrc=5, datac=0xDEADBEEF; the cycle after, enc=0.
- Both valid for 4 cycles, ALU addr=3, MEM addr=4, requests held and re-presented after each grant -> grants alternate ALU, MEM, ALU, MEM; addrc sequence 3, 4, 3, 4.
- rsv_en with rsv_addr=7; next cycle chk_addra=7 -> hazard_a=1. MEM then writes addr 7 -> busy[7] clears at the transfer edge, hazard_a stays 1 while enc=1/addrc=7, then drops to 0.
- Same edge: rsv_en addr=9 and ALU transfer to addr 9 with busy[9]=1 -> busy[9] remains 1.
- ALU transfer to addr 0 with data 0x1234 -> alu_ready=1, enc stays 0. rsv_en addr 0 -> busy stays 0; chk_addrb=0 -> hazard_b=0.
- Assert reset while enc=1 and busy=0x00000F0 -> enc, busy, addrc, datac go to 0 immediately. Release reset, both valid -> ALU granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : regfile_wb_arbiter_if
// Brief  : Writeback request, scoreboard and register-file write-port bundle.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] chk_addra;
    logic [ADDR_W-1:0] chk_addrb;
    logic              hazard_a;
    logic              hazard_b;
    logic              enc;
    logic [ADDR_W-1:0] addrc;
    logic [DATA_W-1:0] datac;
    logic [NREG-1:0]   busy;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  rsv_en, rsv_addr, chk_addra, chk_addrb,
        output alu_ready, mem_ready, hazard_a, hazard_b,
        output enc, addrc, datac, busy
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output rsv_en, rsv_addr, chk_addra, chk_addrb,
        input  alu_ready, mem_ready, hazard_a, hazard_b,
        input  enc, addrc, datac, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : regfile_wb_arbiter
// Brief  : Round-robin ALU/load writeback arbiter with pending-write scoreboard.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  wire                   clock,
    input  wire                   reset,
    regfile_wb_arbiter_if.slave   bus
);
    localparam logic c_GNT_ALU = 1'b0;
    localparam logic c_GNT_MEM = 1'b1;

    logic              r_last_grant;
    logic              r_enc;
    logic [ADDR_W-1:0] r_addrc;
    logic [DATA_W-1:0] r_datac;
    logic [NREG-1:0]   r_busy;

    logic              w_grant_alu;
    logic              w_grant_mem;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_xfer_addr;
    logic [DATA_W-1:0] w_xfer_data;
    logic              w_wr_en;
    logic [NREG-1:0]   w_clr_mask;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_busy_next;
    logic              w_inflight_a;
    logic              w_inflight_b;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!reset) begin
            w_grant_alu = bus.alu_valid && (!bus.mem_valid || (r_last_grant == c_GNT_MEM));
            w_grant_mem = bus.mem_valid && (!bus.alu_valid || (r_last_grant == c_GNT_ALU));
        end
    end

    always_comb begin
        w_xfer      = w_grant_alu || w_grant_mem;
        w_xfer_addr = w_grant_alu ? bus.alu_addr : bus.mem_addr;
        w_xfer_data = w_grant_alu ? bus.alu_data : bus.mem_data;
        w_wr_en     = w_xfer && (w_xfer_addr != '0);
    end

    // Set is applied after clear so a new reservation survives a same-edge writeback.
    always_comb begin
        w_clr_mask  = '0;
        w_set_mask  = '0;
        if (w_xfer) begin
            w_clr_mask = NREG'(1) << w_xfer_addr;
        end
        if (bus.rsv_en && (bus.rsv_addr != '0)) begin
            w_set_mask = NREG'(1) << bus.rsv_addr;
        end
        w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= c_GNT_MEM;
            r_enc        <= 1'b0;
            r_addrc      <= '0;
            r_datac      <= '0;
            r_busy       <= '0;
        end else begin
            r_enc  <= w_wr_en;
            r_busy <= w_busy_next;
            if (w_xfer) begin
                r_last_grant <= w_grant_alu ? c_GNT_ALU : c_GNT_MEM;
            end
            if (w_wr_en) begin
                r_addrc <= w_xfer_addr;
                r_datac <= w_xfer_data;
            end
        end
    end

    // In-flight term: the register file has not committed the write yet.
    always_comb begin
        w_inflight_a = r_enc && (r_addrc == bus.chk_addra);
        w_inflight_b = r_enc && (r_addrc == bus.chk_addrb);
    end

    assign bus.alu_ready = w_grant_alu;
    assign bus.mem_ready = w_grant_mem;
    assign bus.hazard_a  = (bus.chk_addra != '0) && (r_busy[bus.chk_addra] || w_inflight_a);
    assign bus.hazard_b  = (bus.chk_addrb != '0) && (r_busy[bus.chk_addrb] || w_inflight_b);
    assign bus.enc       = r_enc;
    assign bus.addrc     = r_addrc;
    assign bus.datac     = r_datac;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_regfile_wb_arbiter
// Brief  : Directed self-checking bench for regfile_wb_arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_if ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.alu_valid = 1'b0;
        u_if.alu_addr  = '0;
        u_if.alu_data  = '0;
        u_if.mem_valid = 1'b0;
        u_if.mem_addr  = '0;
        u_if.mem_data  = '0;
        u_if.rsv_en    = 1'b0;
        u_if.rsv_addr  = '0;
        u_if.chk_addra = '0;
        u_if.chk_addrb = '0;
    endtask

    task automatic reserve(input logic [ADDR_W-1:0] a);
        u_if.rsv_en   = 1'b1;
        u_if.rsv_addr = a;
        tick();
        u_if.rsv_en   = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset = 1'b1;
        u_if.alu_valid = 1'b1;
        #23;
        check("rst_enc",   u_if.enc,       0);
        check("rst_addrc", u_if.addrc,     0);
        check("rst_datac", u_if.datac,     0);
        check("rst_busy",  u_if.busy,      0);
        check("rst_aready", u_if.alu_ready, 0);
        u_if.alu_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single ALU writeback
        u_if.alu_valid = 1'b1; u_if.alu_addr = 5; u_if.alu_data = 32'hDEADBEEF;
        #1;
        check("t1_aready", u_if.alu_ready, 1);
        check("t1_mready", u_if.mem_ready, 0);
        tick();
        u_if.alu_valid = 1'b0;
        check("t1_enc",   u_if.enc,   1);
        check("t1_addrc", u_if.addrc, 5);
        check("t1_datac", u_if.datac, 32'hDEADBEEF);
        tick();
        check("t1_enc_off",  u_if.enc,   0);
        check("t1_addrhold", u_if.addrc, 5);

        // Lone MEM writeback leaves last_grant at MEM
        u_if.mem_valid = 1'b1; u_if.mem_addr = 6; u_if.mem_data = 32'h66;
        #1;
        check("t1m_mready", u_if.mem_ready, 1);
        tick();
        u_if.mem_valid = 1'b0;
        check("t1m_addrc", u_if.addrc, 6);

        // Round-robin with both requesters held
        u_if.alu_valid = 1'b1; u_if.alu_addr = 3; u_if.alu_data = 32'hA3;
        u_if.mem_valid = 1'b1; u_if.mem_addr = 4; u_if.mem_data = 32'hB4;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_aready", u_if.alu_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_mready", u_if.mem_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            check("rr_enc",   u_if.enc,   1);
            check("rr_addrc", u_if.addrc, (i % 2 == 0) ? 3 : 4);
            check("rr_datac", u_if.datac, (i % 2 == 0) ? 32'hA3 : 32'hB4);
        end
        idle_inputs();

        // Reservation, hazard and in-flight window
        reserve(7);
        check("sb_busy7", u_if.busy[7], 1);
        u_if.chk_addra = 7;
        #1;
        check("sb_haz_rsv", u_if.hazard_a, 1);
        u_if.mem_valid = 1'b1; u_if.mem_addr = 7; u_if.mem_data = 32'h77;
        #1;
        check("sb_mready", u_if.mem_ready, 1);
        tick();
        u_if.mem_valid = 1'b0;
        check("sb_busy7_clr", u_if.busy[7], 0);
        check("sb_enc7",      u_if.enc,     1);
        check("sb_haz_fly",   u_if.hazard_a, 1);
        tick();
        check("sb_haz_done",  u_if.hazard_a, 0);

        // Same-edge set and clear: set wins
        reserve(9);
        check("sc_busy9", u_if.busy[9], 1);
        u_if.rsv_en = 1'b1; u_if.rsv_addr = 9;
        u_if.alu_valid = 1'b1; u_if.alu_addr = 9; u_if.alu_data = 32'h99;
        tick();
        idle_inputs();
        check("sc_busy9_keep", u_if.busy[9], 1);
        check("sc_addrc",      u_if.addrc,   9);

        // Register 0 handling
        u_if.alu_valid = 1'b1; u_if.alu_addr = 0; u_if.alu_data = 32'h1234;
        #1;
        check("r0_aready", u_if.alu_ready, 1);
        tick();
        u_if.alu_valid = 1'b0;
        check("r0_enc", u_if.enc, 0);
        reserve(0);
        check("r0_busy", u_if.busy, 32'h0000_0200);
        u_if.chk_addrb = 0;
        #1;
        check("r0_hazb", u_if.hazard_b, 0);
        u_if.chk_addrb = 9;
        #1;
        check("r9_hazb", u_if.hazard_b, 1);
        idle_inputs();

        // Clear reg 9, then build busy=0xF0 with a write in flight
        u_if.mem_valid = 1'b1; u_if.mem_addr = 9; u_if.mem_data = 32'h9;
        tick();
        u_if.mem_valid = 1'b0;
        reserve(4);
        reserve(5);
        reserve(6);
        u_if.alu_valid = 1'b1; u_if.alu_addr = 3; u_if.alu_data = 32'h33;
        reserve(7);
        u_if.alu_valid = 1'b0;
        check("ar_busy_pre", u_if.busy, 32'h0000_00F0);
        check("ar_enc_pre",  u_if.enc,  1);
        #2;
        reset = 1'b1;
        u_if.alu_valid = 1'b1; u_if.alu_addr = 12; u_if.alu_data = 32'hC;
        u_if.mem_valid = 1'b1; u_if.mem_addr = 13; u_if.mem_data = 32'hD;
        #1;
        check("ar_enc",    u_if.enc,   0);
        check("ar_busy",   u_if.busy,  0);
        check("ar_addrc",  u_if.addrc, 0);
        check("ar_datac",  u_if.datac, 0);
        check("ar_mready", u_if.mem_ready, 0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_first_alu", u_if.alu_ready, 1);
        check("ar_first_mem", u_if.mem_ready, 0);
        tick();
        check("ar_addrc_alu", u_if.addrc, 12);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
